// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each accepted request runs IDLE -> EXEC -> RESP and returns its result over a valid/ready handshake.
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_A0,
    input  logic [WIDTH-1:0] req_B0,
    input  logic [WIDTH-1:0] req_A1,
    input  logic [WIDTH-1:0] req_B1,
    input  logic [SEL_W-1:0] req_sel0,
    input  logic [SEL_W-1:0] req_sel1,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [SEL_W-1:0] ALU_Sel,
    input  logic [WIDTH-1:0] ALU_Out,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    // state  | meaning
    // S_IDLE | waiting for a request; grant decoded from req_valid and r_prio
    // S_EXEC | operands driven to the ALU for one cycle, result captured at its end
    // S_RESP | result offered to r_owner until it takes it
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic               r_owner;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [SEL_W-1:0]   r_sel;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [1:0]         r_rsp_valid;
    logic               w_grant_valid;
    logic               w_grant;
    logic               w_rsp_done;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = 1'b0;
        if (r_state == S_IDLE) begin
            case (req_valid)
                2'b01:   begin w_grant_valid = 1'b1; w_grant = 1'b0;   end
                2'b10:   begin w_grant_valid = 1'b1; w_grant = 1'b1;   end
                2'b11:   begin w_grant_valid = 1'b1; w_grant = r_prio; end
                default: begin w_grant_valid = 1'b0; w_grant = 1'b0;   end
            endcase
        end
    end

    assign req_ready  = w_grant_valid ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_owner];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Operand registers only move on accept, so they hold through RESP and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sel       <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 2'b00;
        end else begin
            if (w_grant_valid) begin
                r_a     <= w_grant ? req_A1   : req_A0;
                r_b     <= w_grant ? req_B1   : req_B0;
                r_sel   <= w_grant ? req_sel1 : req_sel0;
                r_owner <= w_grant;
                r_prio  <= ~w_grant;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data  <= ALU_Out;
                r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            end
            if (w_rsp_done) r_rsp_valid <= 2'b00;
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign ALU_Sel   = r_sel;
    assign rsp_data  = r_rsp_data;
    assign rsp_valid = r_rsp_valid;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed checks of alu_arbiter against a transaction-level model,
// using an adder as the stand-in ALU.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_A0, req_B0, req_A1, req_B1;
    logic [SEL_W-1:0] req_sel0, req_sel1;
    logic [WIDTH-1:0] A, B;
    logic [SEL_W-1:0] ALU_Sel;
    logic [WIDTH-1:0] ALU_Out;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;

    // model state: who wins a tie next, and the last accept time for throughput
    logic m_prio;
    int   last_acc;
    logic last_fast;

    alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_A0    (req_A0),
        .req_B0    (req_B0),
        .req_A1    (req_A1),
        .req_B1    (req_B1),
        .req_sel0  (req_sel0),
        .req_sel1  (req_sel1),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .ALU_Out   (ALU_Out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    assign ALU_Out = A + B;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full transaction, entered just after a clock edge with the DUT in IDLE.
    task automatic run_op(input logic [1:0] vld, input int stall);
        logic             w;
        logic [1:0]       oh;
        logic [WIDTH-1:0] ea, eb, er;
        logic [SEL_W-1:0] es;
        req_valid = vld;
        rsp_ready = 2'b00;
        w  = (vld == 2'b11) ? m_prio : vld[1];
        oh = w ? 2'b10 : 2'b01;
        ea = w ? req_A1 : req_A0;
        eb = w ? req_B1 : req_B0;
        es = w ? req_sel1 : req_sel0;
        er = WIDTH'(32'(ea) + 32'(eb));

        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'(oh));
        check_eq("busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        m_prio = ~w;
        if (last_fast) check_eq("accept_gap", 32'(cyc - last_acc), 32'd3);
        last_acc  = cyc;
        last_fast = (stall == 0);
        rsp_ready = ~oh & 2'($urandom);

        @(negedge clk);
        check_eq("exec_A", 32'(A), 32'(ea));
        check_eq("exec_B", 32'(B), 32'(eb));
        check_eq("exec_sel", 32'(ALU_Sel), 32'(es));
        check_eq("exec_busy", 32'(busy), 32'd1);
        check_eq("exec_req_ready", 32'(req_ready), 32'd0);
        check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i <= stall; i++) begin
            if (i == stall) rsp_ready = oh | (~oh & 2'($urandom));
            @(negedge clk);
            check_eq("resp_valid", 32'(rsp_valid), 32'(oh));
            check_eq("resp_data", 32'(rsp_data), 32'(er));
            check_eq("resp_busy", 32'(busy), 32'd1);
            check_eq("resp_req_ready", 32'(req_ready), 32'd0);
            check_eq("resp_A_hold", 32'(A), 32'(ea));
            @(posedge clk); #1;
        end
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check_eq({tag, "_A"}, 32'(A), 32'd0);
        check_eq({tag, "_B"}, 32'(B), 32'd0);
        check_eq({tag, "_sel"}, 32'(ALU_Sel), 32'd0);
    endtask

    // Start a tied request, pulse reset after `depth` cycles of the operation.
    task automatic reset_mid(input int depth, input string tag);
        req_A0 = 16'h1234; req_B0 = 16'h1111; req_sel0 = 3'h5;
        req_A1 = 16'h4321; req_B1 = 16'h2222; req_sel1 = 3'h6;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        repeat (depth) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_prio    = 1'b0;
        last_fast = 1'b0;
        check_reset_state(tag);
        @(negedge clk);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // the accept above went to requester 0; finish it through the model path
        m_prio = 1'b1;
        @(negedge clk);
        check_eq({tag, "_regrant_A"}, 32'(A), 32'h1234);
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        @(negedge clk);
        check_eq({tag, "_regrant_rsp"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_regrant_data"}, 32'(rsp_data), 32'h2345);
        @(posedge clk); #1;
        req_valid = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_A0 = '0; req_B0 = '0; req_A1 = '0; req_B1 = '0;
        req_sel0 = '0; req_sel1 = '0;
        m_prio = 1'b0; last_acc = 0; last_fast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_state("reset");

        // single request from requester 0
        req_A0 = 16'h0AB0; req_B0 = 16'h01AC; req_sel0 = 3'h1;
        run_op(2'b01, 0);

        // simultaneous requests, requester 0 first after reset
        req_A0 = 16'h0001; req_B0 = 16'h0002; req_sel0 = 3'h2;
        req_A1 = 16'h0010; req_B1 = 16'h0020; req_sel1 = 3'h3;
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        m_prio = 1'b0; last_fast = 1'b0;
        run_op(2'b11, 0);
        run_op(2'b11, 0);

        // fairness and back-to-back throughput
        for (int i = 0; i < 6; i++) begin
            req_A0 = 16'($urandom); req_B0 = 16'($urandom); req_sel0 = 3'($urandom);
            req_A1 = 16'($urandom); req_B1 = 16'($urandom); req_sel1 = 3'($urandom);
            run_op(2'b11, 0);
        end

        // response backpressure
        req_A1 = 16'h5A5A; req_B1 = 16'h0101; req_sel1 = 3'h7;
        run_op(2'b10, 5);

        // wrap-around is the ALU's business; result must pass through intact
        req_A0 = 16'hFFFF; req_B0 = 16'h0002; req_sel0 = 3'h0;
        run_op(2'b01, 0);

        reset_mid(1, "rst_exec");
        reset_mid(2, "rst_resp");

        for (int i = 0; i < 40; i++) begin
            req_A0 = 16'($urandom); req_B0 = 16'($urandom); req_sel0 = 3'($urandom);
            req_A1 = 16'($urandom); req_B1 = 16'($urandom); req_sel1 = 3'($urandom);
            run_op(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
